// File: rtl/destuff_rx_ctrl.sv
// destuff_rx_ctrl: receive-side bit de-stuffer and word assembler.
// Serial bits arrive MSB first. A zero that follows RUN_LEN consecutive ones
// is a stuffed bit and is dropped. A one in that position is an abort.
// Completed words are offered downstream and FRAME_LEN words make a frame.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holding valid keeps its
// data stable until that edge. The serial side here is the consumer
// (serReady). The word side here is the producer (dataValid/dataOut), and
// dataValid never depends combinationally on dataReady.
module destuff_rx_ctrl #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  parameter int RUN_LEN   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              serIn,
  input  logic              serValid,
  output logic              serReady,
  output logic [DATA_W-1:0] dataOut,
  output logic              dataValid,
  input  logic              dataReady,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        fsm_state
);

  localparam int OC_W = $clog2(RUN_LEN + 1);
  localparam int BC_W = $clog2(DATA_W);
  localparam int WC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [OC_W-1:0] RUN_MAX   = OC_W'(RUN_LEN);
  localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(DATA_W - 1);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RECV = 3'd1,
    S_HOLD = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state, state_nx;
  // Only the first DATA_W-1 bits of a word are ever parked here; the final
  // bit goes straight into dataOut together with them.
  logic [DATA_W-2:0] shreg, shreg_nx;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_nx;
  logic [OC_W-1:0]   ones_cnt, ones_cnt_nx;
  logic [WC_W-1:0]   word_cnt, word_cnt_nx;
  logic [DATA_W-1:0] data_out_nx;
  logic              data_valid_nx;
  logic [DATA_W-1:0] shifted;
  logic              take;
  logic              run_full;

  assign take     = serValid & serReady;
  assign run_full = (ones_cnt == RUN_MAX);
  assign shifted  = {shreg, serIn};

  // Status outputs decode directly from the state register.
  always_comb begin
    serReady  = (state == S_RECV);
    busy      = (state == S_RECV) || (state == S_HOLD);
    done      = (state == S_DONE);
    err       = (state == S_ERR);
    fsm_state = state;
  end

  // Next-state and datapath update.
  always_comb begin
    state_nx      = state;
    shreg_nx      = shreg;
    bit_cnt_nx    = bit_cnt;
    ones_cnt_nx   = ones_cnt;
    word_cnt_nx   = word_cnt;
    data_out_nx   = dataOut;
    data_valid_nx = dataValid;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx    = S_RECV;
          shreg_nx    = '0;
          bit_cnt_nx  = '0;
          ones_cnt_nx = '0;
          word_cnt_nx = '0;
        end
      end
      S_RECV: begin
        if (take) begin
          if (serIn && run_full) begin
            // Too many ones: abort the frame and drop the partial word.
            state_nx    = S_ERR;
            shreg_nx    = '0;
            bit_cnt_nx  = '0;
            ones_cnt_nx = '0;
          end else if (!serIn && run_full) begin
            // Stuffed zero: consumed but not part of the data.
            ones_cnt_nx = '0;
          end else begin
            ones_cnt_nx = serIn ? (ones_cnt + OC_W'(1)) : '0;
            shreg_nx    = shifted[DATA_W-2:0];
            if (bit_cnt == LAST_BIT) begin
              data_out_nx   = shifted;
              data_valid_nx = 1'b1;
              bit_cnt_nx    = '0;
              state_nx      = S_HOLD;
            end else begin
              bit_cnt_nx = bit_cnt + BC_W'(1);
            end
          end
        end
      end
      S_HOLD: begin
        if (dataValid && dataReady) begin
          data_valid_nx = 1'b0;
          if (word_cnt == LAST_WORD) begin
            state_nx = S_DONE;
          end else begin
            word_cnt_nx = word_cnt + WC_W'(1);
            state_nx    = S_RECV;
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      S_ERR: begin
        if (start) begin
          state_nx    = S_RECV;
          shreg_nx    = '0;
          bit_cnt_nx  = '0;
          ones_cnt_nx = '0;
          word_cnt_nx = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      word_cnt  <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      bit_cnt   <= bit_cnt_nx;
      ones_cnt  <= ones_cnt_nx;
      word_cnt  <= word_cnt_nx;
      dataOut   <= data_out_nx;
      dataValid <= data_valid_nx;
    end
  end

endmodule

// File: tb/tb_destuff_rx_ctrl.sv
// Directed bench for destuff_rx_ctrl with two-word frames.
module tb_destuff_rx_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RECV = 3'd1;
  localparam logic [2:0] ST_HOLD = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       serIn = 1'b0;
  logic       serValid = 1'b0;
  logic       serReady;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       dataReady = 1'b1;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] fsm_state;

  int checks = 0;
  int errors = 0;

  // Clock and reset
  always #5 clk = ~clk;

  destuff_rx_ctrl #(.DATA_W(8), .FRAME_LEN(2), .RUN_LEN(5)) dut (
    .clk(clk), .rst(rst), .start(start), .serIn(serIn), .serValid(serValid),
    .serReady(serReady), .dataOut(dataOut), .dataValid(dataValid),
    .dataReady(dataReady), .busy(busy), .done(done), .err(err),
    .fsm_state(fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_seq(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      serValid = 1'b1;
      serIn    = v[i];
      tick();
    end
    serValid = 1'b0;
  endtask

  task automatic begin_frame(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_rdy"}, serReady, 1);
  endtask

  task automatic expect_word(input string tag, input logic [7:0] w);
    check({tag, "_valid"}, dataValid, 1);
    check({tag, "_data"}, dataOut, w);
    check({tag, "_rdy"}, serReady, 0);
    check({tag, "_st"}, fsm_state, ST_HOLD);
  endtask

  task automatic expect_frame_end(input string tag);
    tick();
    check({tag, "_done"}, done, 1);
    check({tag, "_stdone"}, fsm_state, ST_DONE);
    check({tag, "_vld0"}, dataValid, 0);
    tick();
    check({tag, "_done0"}, done, 0);
    check({tag, "_idle"}, fsm_state, ST_IDLE);
    check({tag, "_busy0"}, busy, 0);
  endtask

  initial begin
    // reset state
    #2;
    check("rst_rdy", serReady, 0);
    check("rst_valid", dataValid, 0);
    check("rst_data", dataOut, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_state", fsm_state, ST_IDLE);
    tick();
    rst = 1'b0;
    tick();
    check("idle_hold", fsm_state, ST_IDLE);

    // 1: two plain words
    begin_frame("t1");
    send_seq(16'hA5, 8);
    expect_word("t1_w0", 8'hA5);
    tick();
    check("t1_w0_ack", dataValid, 0);
    check("t1_recv", fsm_state, ST_RECV);
    send_seq(16'h3C, 8);
    expect_word("t1_w1", 8'h3C);
    expect_frame_end("t1");

    // 2: stuffed zero inside words
    begin_frame("t2");
    send_seq(16'b111110111, 9);
    expect_word("t2_w0", 8'hFF);
    tick();
    send_seq(16'b011111010, 9);
    expect_word("t2_w1", 8'h7E);
    expect_frame_end("t2");

    // 2b: ones run carried across the word boundary, stuffed zero opens word 2
    begin_frame("t2b");
    send_seq(16'b00011111, 8);
    expect_word("t2b_w0", 8'h1F);
    tick();
    send_seq(16'b010101010, 9);
    expect_word("t2b_w1", 8'hAA);
    expect_frame_end("t2b");

    // 3: backpressure, serial side kept offering ones during the hold
    begin_frame("t3");
    dataReady = 1'b0;
    send_seq(16'hA5, 8);
    serValid = 1'b1;
    serIn    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_rdy", serReady, 0);
      check("t3_hold_data", dataOut, 8'hA5);
      check("t3_hold_valid", dataValid, 1);
      tick();
    end
    dataReady = 1'b1;
    check("t3_c6_valid", dataValid, 1);
    check("t3_c6_data", dataOut, 8'hA5);
    tick();
    serValid = 1'b0;
    check("t3_ack", dataValid, 0);
    check("t3_recv", fsm_state, ST_RECV);
    send_seq(16'h3C, 8);
    expect_word("t3_w1", 8'h3C);
    expect_frame_end("t3");

    // 4: abort on six ones, then restart
    begin_frame("t4");
    send_seq(16'b111111, 6);
    check("t4_err", err, 1);
    check("t4_rdy", serReady, 0);
    check("t4_valid", dataValid, 0);
    check("t4_busy", busy, 0);
    check("t4_state", fsm_state, ST_ERR);
    tick();
    check("t4_err_held", err, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_err0", err, 0);
    check("t4_busy1", busy, 1);
    check("t4_rdy1", serReady, 1);

    // 5: 0x5A with random serValid gaps (random serIn during gaps)
    begin
      logic [7:0] w;
      w = 8'h5A;
      for (int i = 7; i >= 0; i--) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          serValid = 1'b0;
          serIn    = 1'($urandom_range(0, 1));
          tick();
        end
        if (i == 0) check("t5_novalid", dataValid, 0);
        serValid = 1'b1;
        serIn    = w[i];
        tick();
      end
      serValid = 1'b0;
      expect_word("t5", 8'h5A);
    end
    tick();
    check("t5_recv", fsm_state, ST_RECV);

    // 6: reset in the middle of a word, then a clean frame
    send_seq(16'b110, 3);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rdy", serReady, 0);
    check("t6_valid", dataValid, 0);
    check("t6_data", dataOut, 0);
    check("t6_busy", busy, 0);
    check("t6_state", fsm_state, ST_IDLE);
    tick();
    rst = 1'b0;
    tick();
    begin_frame("t6");
    send_seq(16'h81, 8);
    expect_word("t6_w0", 8'h81);
    tick();
    check("t6_word0_recv", fsm_state, ST_RECV);
    send_seq(16'h3C, 8);
    expect_word("t6_w1", 8'h3C);
    expect_frame_end("t6");

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
